// File: rtl/dcache_mem_responder.sv
// Responder between dcache controller ports and NUM_CHANNELS memory channels.
// Round-robin lane allocation, per-channel request FSMs, all outputs registered.
module dcache_mem_responder #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 2
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

   localparam int LW  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   localparam int LW1 = LW + 1;

   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_READ_WAIT   = 3'd1;
   localparam logic [2:0] ST_WRITE_WAIT  = 3'd2;
   localparam logic [2:0] ST_READ_RELAY  = 3'd3;
   localparam logic [2:0] ST_WRITE_RELAY = 3'd4;

   logic [2:0]               r_state [NUM_CHANNELS];
   logic [LW-1:0]            r_lane  [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] r_claim;
   logic [LW-1:0]            r_rr;

   logic [NUM_CHANNELS-1:0]  w_grant;
   logic [NUM_CHANNELS-1:0]  w_grant_read;
   logic [LW-1:0]            w_grant_lane [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] w_taken;
   logic [NUM_CONSUMERS-1:0] w_req;
   logic [LW-1:0]            w_rr_next;
   logic [LW-1:0]            w_cand;

   // Lane index base+off, wrapped modulo NUM_CONSUMERS (off < NUM_CONSUMERS).
   function automatic logic [LW-1:0] wrap_lane(input logic [LW-1:0] base, input int off);
      logic [LW:0] sum;
      sum = {1'b0, base} + LW1'(off);
      sum = (sum >= LW1'(NUM_CONSUMERS)) ? (sum - LW1'(NUM_CONSUMERS)) : sum;
      return sum[LW-1:0];
   endfunction

   assign w_req = consumer_read_valid | consumer_write_valid;

   // Channel-ordered allocation: each IDLE channel takes the first free requesting lane from rr.
   always_comb begin
      w_grant      = '0;
      w_grant_read = '0;
      w_taken      = '0;
      w_rr_next    = r_rr;
      w_cand       = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         w_grant_lane[c] = '0;
         for (int k = 0; k < NUM_CONSUMERS; k++) begin
            w_cand = wrap_lane(r_rr, k);
            if ((r_state[c] == ST_IDLE) && !w_grant[c] && w_req[w_cand] &&
                !r_claim[w_cand] && !w_taken[w_cand]) begin
               w_grant[c]      = 1'b1;
               w_grant_lane[c] = w_cand;
               w_grant_read[c] = consumer_read_valid[w_cand];
               w_taken[w_cand] = 1'b1;
               w_rr_next       = wrap_lane(w_cand, 1);
            end else begin
               w_grant[c] = w_grant[c];
            end
         end
      end
   end

   // Channel FSMs, claim mask, round-robin pointer and every registered output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_claim              <= '0;
         r_rr                 <= '0;
         consumer_read_ready  <= '0;
         consumer_read_data   <= '0;
         consumer_write_ready <= '0;
         mem_read_valid       <= '0;
         mem_read_address     <= '0;
         mem_write_valid      <= '0;
         mem_write_address    <= '0;
         mem_write_data       <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            r_state[c] <= ST_IDLE;
            r_lane[c]  <= '0;
         end
      end else begin
         r_rr <= w_rr_next;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (r_state[c])
               ST_IDLE: begin
                  if (w_grant[c]) begin
                     r_claim[w_grant_lane[c]] <= 1'b1;
                     r_lane[c]                <= w_grant_lane[c];
                     if (w_grant_read[c]) begin
                        mem_read_valid[c]   <= 1'b1;
                        mem_read_address[c] <= consumer_read_address[w_grant_lane[c]];
                        r_state[c]          <= ST_READ_WAIT;
                     end else begin
                        mem_write_valid[c]   <= 1'b1;
                        mem_write_address[c] <= consumer_write_address[w_grant_lane[c]];
                        mem_write_data[c]    <= consumer_write_data[w_grant_lane[c]];
                        r_state[c]           <= ST_WRITE_WAIT;
                     end
                  end
               end
               ST_READ_WAIT: begin
                  if (mem_read_ready[c]) begin
                     mem_read_valid[c]              <= 1'b0;
                     consumer_read_data[r_lane[c]]  <= mem_read_data[c];
                     consumer_read_ready[r_lane[c]] <= 1'b1;
                     r_state[c]                     <= ST_READ_RELAY;
                  end
               end
               ST_WRITE_WAIT: begin
                  if (mem_write_ready[c]) begin
                     mem_write_valid[c]              <= 1'b0;
                     consumer_write_ready[r_lane[c]] <= 1'b1;
                     r_state[c]                      <= ST_WRITE_RELAY;
                  end
               end
               // Claim stays set through this edge, so the lane cannot be re-granted in the release cycle.
               ST_READ_RELAY: begin
                  if (!consumer_read_valid[r_lane[c]]) begin
                     consumer_read_ready[r_lane[c]] <= 1'b0;
                     r_claim[r_lane[c]]             <= 1'b0;
                     r_state[c]                     <= ST_IDLE;
                  end
               end
               ST_WRITE_RELAY: begin
                  if (!consumer_write_valid[r_lane[c]]) begin
                     consumer_write_ready[r_lane[c]] <= 1'b0;
                     r_claim[r_lane[c]]              <= 1'b0;
                     r_state[c]                      <= ST_IDLE;
                  end
               end
               default: begin
                  r_state[c] <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
